// File: rtl/stack_mem_arbiter.sv
// stack_mem_arbiter: two LIFO stacks (A = operand, B = operator) sharing one
// single-port synchronous RAM (1-cycle read latency). Stack A occupies
// addresses 0..DEPTH-1 and stack B occupies DEPTH..2*DEPTH-1. A small FSM
// serialises the RAM accesses, with round-robin arbitration on ties.
module stack_mem_arbiter #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    // requester A (operand stack)
    input  logic              a_push,
    input  logic              a_pop,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_ack,
    output logic              a_err,
    output logic              a_full,
    output logic              a_empty,
    output logic [ADDR_W-1:0] a_cnt,
    // requester B (operator stack)
    input  logic              b_push,
    input  logic              b_pop,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_ack,
    output logic              b_err,
    output logic              b_full,
    output logic              b_empty,
    output logic [ADDR_W-1:0] b_cnt,
    // shared RAM port
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RDW  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LP_DEPTH = ADDR_W'(DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sel;       // requester owning the current access: 0=A, 1=B
    logic              r_last;      // last granted requester: 0=A, 1=B
    logic [ADDR_W-1:0] r_a_cnt;
    logic [ADDR_W-1:0] r_b_cnt;
    logic [DATA_W-1:0] r_a_dout;
    logic [DATA_W-1:0] r_b_dout;
    logic              r_a_err;
    logic              r_b_err;

    logic              w_a_full, w_a_empty, w_b_full, w_b_empty;
    logic              w_a_req, w_b_req;
    logic              w_a_ok, w_b_ok;
    logic              w_a_legal, w_b_legal;
    logic              w_a_bad, w_b_bad;
    logic              w_gnt;
    logic              w_gnt_b;
    logic              w_gnt_push;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_sel_cnt;
    logic [DATA_W-1:0] w_sel_din;

    assign w_a_full  = (r_a_cnt == LP_DEPTH);
    assign w_a_empty = (r_a_cnt == '0);
    assign w_b_full  = (r_b_cnt == LP_DEPTH);
    assign w_b_empty = (r_b_cnt == '0);

    // A requester is ignored during its own err pulse so a held request is
    // not rejected twice; push wins when push and pop are both asserted.
    assign w_a_req   = (a_push | a_pop) & ~r_a_err;
    assign w_b_req   = (b_push | b_pop) & ~r_b_err;
    assign w_a_ok    = a_push ? ~w_a_full : ~w_a_empty;
    assign w_b_ok    = b_push ? ~w_b_full : ~w_b_empty;
    assign w_a_legal = w_a_req & w_a_ok;
    assign w_b_legal = w_b_req & w_b_ok;
    assign w_a_bad   = w_a_req & ~w_a_ok;
    assign w_b_bad   = w_b_req & ~w_b_ok;

    assign w_base    = r_sel ? LP_DEPTH : '0;
    assign w_sel_cnt = r_sel ? r_b_cnt : r_a_cnt;
    assign w_sel_din = r_sel ? b_din : a_din;

    // Next-state logic and arbitration (B wins a tie only if A was granted last)
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 1'b0;
        w_gnt_b     = r_sel;
        w_gnt_push  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_a_legal | w_b_legal) begin
                    w_gnt       = 1'b1;
                    w_gnt_b     = w_b_legal & (~w_a_legal | ~r_last);
                    w_gnt_push  = w_gnt_b ? b_push : a_push;
                    w_state_nxt = w_gnt_push ? WR : RD;
                end
            end
            WR:      w_state_nxt = IDLE;
            RD:      w_state_nxt = RDW;
            RDW:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state, grant ownership and round-robin history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt) begin
                r_sel  <= w_gnt_b;
                r_last <= w_gnt_b;
            end
        end
    end

    // Stack pointers, popped data and reject pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_cnt  <= '0;
            r_b_cnt  <= '0;
            r_a_dout <= '0;
            r_b_dout <= '0;
            r_a_err  <= 1'b0;
            r_b_err  <= 1'b0;
        end else begin
            r_a_err <= (r_state == IDLE) & w_a_bad;
            r_b_err <= (r_state == IDLE) & w_b_bad;
            if (r_state == WR) begin
                if (r_sel) r_b_cnt <= r_b_cnt + 1'b1;
                else       r_a_cnt <= r_a_cnt + 1'b1;
            end
            if (r_state == RD) begin
                if (r_sel) r_b_cnt <= r_b_cnt - 1'b1;
                else       r_a_cnt <= r_a_cnt - 1'b1;
            end
            if (r_state == RDW) begin
                if (r_sel) r_b_dout <= mem_rdata;
                else       r_a_dout <= mem_rdata;
            end
        end
    end

    // RAM port: write in WR, read address (top entry) in RD, quiet otherwise
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (r_state == WR) begin
            mem_we    = 1'b1;
            mem_addr  = w_base + w_sel_cnt;
            mem_wdata = w_sel_din;
        end else if (r_state == RD) begin
            mem_addr  = w_base + w_sel_cnt - 1'b1;
        end
    end

    assign a_ack   = ((r_state == WR) || (r_state == RDW)) && !r_sel;
    assign b_ack   = ((r_state == WR) || (r_state == RDW)) &&  r_sel;
    assign a_err   = r_a_err;
    assign b_err   = r_b_err;
    assign a_dout  = r_a_dout;
    assign b_dout  = r_b_dout;
    assign a_cnt   = r_a_cnt;
    assign b_cnt   = r_b_cnt;
    assign a_full  = w_a_full;
    assign a_empty = w_a_empty;
    assign b_full  = w_b_full;
    assign b_empty = w_b_empty;

endmodule

// File: tb/tb_stack_mem_arbiter.sv
// Directed testbench for stack_mem_arbiter with a behavioural 1-cycle RAM.
module tb_stack_mem_arbiter;

    logic       clk;
    logic       rst;
    logic       a_push, a_pop, b_push, b_pop;
    logic [7:0] a_din, b_din, a_dout, b_dout;
    logic       a_ack, a_err, a_full, a_empty;
    logic       b_ack, b_err, b_full, b_empty;
    logic [3:0] a_cnt, b_cnt;
    logic [3:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata, mem_rdata;
    logic [7:0] ram [0:15];

    int n_checks = 0;
    int n_fail   = 0;

    stack_mem_arbiter #(.DATA_W(8), .DEPTH(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .a_push(a_push), .a_pop(a_pop), .a_din(a_din), .a_dout(a_dout),
        .a_ack(a_ack), .a_err(a_err), .a_full(a_full), .a_empty(a_empty), .a_cnt(a_cnt),
        .b_push(b_push), .b_pop(b_pop), .b_din(b_din), .b_dout(b_dout),
        .b_ack(b_ack), .b_err(b_err), .b_full(b_full), .b_empty(b_empty), .b_cnt(b_cnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-port synchronous RAM, read data one cycle after the address
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that ends the ack cycle.
    task automatic push_chk(input bit isb, input logic [7:0] d, input int exp_addr, input int exp_cnt);
        if (isb) begin b_push = 1'b1; b_din = d; end
        else     begin a_push = 1'b1; a_din = d; end
        @(negedge clk);
        check("push_idle_we", 32'(mem_we), 0);
        @(negedge clk);
        check("push_we", 32'(mem_we), 1);
        check("push_addr", 32'(mem_addr), exp_addr);
        check("push_wdata", 32'(mem_wdata), 32'(d));
        check("push_ack", 32'(isb ? b_ack : a_ack), 1);
        check("push_other_ack", 32'(isb ? a_ack : b_ack), 0);
        @(posedge clk); #1;
        if (isb) b_push = 1'b0; else a_push = 1'b0;
        check("push_cnt", 32'(isb ? b_cnt : a_cnt), exp_cnt);
    endtask

    task automatic pop_chk(input bit isb, input int exp_addr, input logic [7:0] exp_dout, input int exp_cnt);
        if (isb) b_pop = 1'b1; else a_pop = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pop_rd_addr", 32'(mem_addr), exp_addr);
        check("pop_rd_we", 32'(mem_we), 0);
        check("pop_rd_ack", 32'(isb ? b_ack : a_ack), 0);
        @(negedge clk);
        check("pop_rdw_ack", 32'(isb ? b_ack : a_ack), 1);
        @(posedge clk); #1;
        if (isb) b_pop = 1'b0; else a_pop = 1'b0;
        check("pop_dout", 32'(isb ? b_dout : a_dout), 32'(exp_dout));
        check("pop_cnt", 32'(isb ? b_cnt : a_cnt), exp_cnt);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        a_push = 1'b0; a_pop = 1'b0; a_din = 8'h00;
        b_push = 1'b0; b_pop = 1'b0; b_din = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_cnt", 32'(a_cnt), 0);
        check("rst_b_cnt", 32'(b_cnt), 0);
        check("rst_a_empty", 32'(a_empty), 1);
        check("rst_a_full", 32'(a_full), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_acks", 32'({a_ack, b_ack, a_err, b_err}), 0);
        check("rst_dout", 32'({a_dout, b_dout}), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // A pushes two values, pops them back, then pops an empty stack
        push_chk(1'b0, 8'h11, 0, 1);
        push_chk(1'b0, 8'h22, 1, 2);
        pop_chk(1'b0, 1, 8'h22, 1);
        pop_chk(1'b0, 0, 8'h11, 0);
        a_pop = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("a_pop_empty_err", 32'(a_err), 1);
        check("a_pop_empty_ack", 32'(a_ack), 0);
        check("a_pop_empty_we", 32'(mem_we), 0);
        @(posedge clk); #1;
        a_pop = 1'b0;
        @(negedge clk);
        check("a_err_one_cycle", 32'(a_err), 0);
        check("a_dout_held", 32'(a_dout), 32'h11);
        check("a_cnt_after_err", 32'(a_cnt), 0);

        // simultaneous pushes: A first from reset, then B; after a solo A grant, tie goes to B
        do_reset();
        a_push = 1'b1; b_push = 1'b1; a_din = 8'h33; b_din = 8'h44;
        @(negedge clk);
        @(negedge clk);
        check("tie1_a_ack", 32'(a_ack), 1);
        check("tie1_b_ack", 32'(b_ack), 0);
        check("tie1_addr", 32'(mem_addr), 0);
        @(posedge clk); #1;
        a_push = 1'b0;
        @(negedge clk);
        check("tie1_idle_we", 32'(mem_we), 0);
        @(negedge clk);
        check("tie1_b_ack2", 32'(b_ack), 1);
        check("tie1_b_addr", 32'(mem_addr), 8);
        check("tie1_b_wdata", 32'(mem_wdata), 32'h44);
        @(posedge clk); #1;
        b_push = 1'b0;
        push_chk(1'b0, 8'h3C, 1, 2);
        a_push = 1'b1; b_push = 1'b1; a_din = 8'h55; b_din = 8'h66;
        @(negedge clk);
        @(negedge clk);
        check("tie2_b_ack", 32'(b_ack), 1);
        check("tie2_a_ack", 32'(a_ack), 0);
        check("tie2_b_addr", 32'(mem_addr), 9);
        check("tie2_b_wdata", 32'(mem_wdata), 32'h66);
        @(posedge clk); #1;
        b_push = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("tie2_a_ack2", 32'(a_ack), 1);
        check("tie2_a_addr", 32'(mem_addr), 2);
        check("tie2_a_wdata", 32'(mem_wdata), 32'h55);
        @(posedge clk); #1;
        a_push = 1'b0;
        check("tie2_a_cnt", 32'(a_cnt), 3);
        check("tie2_b_cnt", 32'(b_cnt), 2);

        // fill B, then a ninth push on full is rejected
        do_reset();
        for (int i = 0; i < 8; i++) push_chk(1'b1, 8'(8'hA0 + i), 8 + i, i + 1);
        check("b_full", 32'(b_full), 1);
        check("b_not_empty", 32'(b_empty), 0);
        b_push = 1'b1; b_din = 8'hEE;
        @(negedge clk);
        @(negedge clk);
        check("b_full_err", 32'(b_err), 1);
        check("b_full_ack", 32'(b_ack), 0);
        check("b_full_we", 32'(mem_we), 0);
        @(posedge clk); #1;
        b_push = 1'b0;
        check("b_full_cnt", 32'(b_cnt), 8);

        // reset asserted while B's pop is in RD aborts it
        b_pop = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_rd_addr", 32'(mem_addr), 15);
        rst = 1'b0;
        #1;
        check("abort_b_cnt", 32'(b_cnt), 0);
        check("abort_b_ack", 32'(b_ack), 0);
        check("abort_addr", 32'(mem_addr), 0);
        check("abort_b_empty", 32'(b_empty), 1);
        b_pop = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_no_ack", 32'({a_ack, b_ack}), 0);
        check("abort_b_dout", 32'(b_dout), 0);
        @(posedge clk); #1;
        push_chk(1'b0, 8'h77, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
